// File: rtl/kf6845_pkg.sv
// Shared types, widths and helpers for the KF6845 timing sequencer.
package kf6845_pkg;

  localparam int H_W    = 8;
  localparam int ROW_W  = 7;
  localparam int RA_W   = 5;
  localparam int SYNC_W = 4;

  // Vertical sequencing: character rows first, then the optional adjust lines.
  typedef enum logic {
    ST_ROWS   = 1'b0,
    ST_ADJUST = 1'b1
  } vstate_t;

  // Effective sync pulse length in step periods (0 means no pulse at all).
  function automatic logic [SYNC_W:0] sync_len(
    input logic [SYNC_W-1:0] width,
    input logic              zero_is_16
  );
    logic [SYNC_W:0] len;
    if (width != '0) begin
      len = {1'b0, width};
    end else if (zero_is_16) begin
      len = 5'd16;
    end else begin
      len = '0;
    end
    return len;
  endfunction

endpackage

// File: rtl/kf6845_sync_pulse_generator.sv
// Programmable-width sync pulse: rises on start, lasts width step periods.
// A start while the pulse is already active reloads the counter.
module kf6845_sync_pulse_generator
  import kf6845_pkg::*;
#(
  parameter bit ZERO_IS_16 = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step,
  input  logic [SYNC_W-1:0] width,
  output logic              pulse
);

  logic [SYNC_W:0]   w_len;
  logic [SYNC_W-1:0] w_load;
  logic              r_pulse;
  logic [SYNC_W-1:0] r_cnt;

  assign w_len  = sync_len(width, ZERO_IS_16);
  // width-1 in four bits also yields 15 for the 0-means-16 case.
  assign w_load = width - 4'd1;

  // Load on start (when a pulse is wanted), otherwise count down on step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else if (start && (w_len != '0)) begin
      r_pulse <= 1'b1;
      r_cnt   <= w_load;
    end else if (r_pulse && step) begin
      if (r_cnt == '0) begin
        r_pulse <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/kf6845_timing_sequencer.sv
// KF6845 horizontal/vertical timing: character, scanline and row counters,
// sequencing strobes for the address generator, syncs, DE and RA.
module kf6845_timing_sequencer
  import kf6845_pkg::*;
#(
  parameter bit SYNC_ZERO_IS_16 = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             video_clock_enable,
  input  logic [H_W-1:0]   horizontal_total,
  input  logic [H_W-1:0]   horizontal_displayed,
  input  logic [H_W-1:0]   h_sync_position,
  input  logic [7:0]       sync_width,
  input  logic [ROW_W-1:0] vertical_total,
  input  logic [RA_W-1:0]  vertical_total_adjust,
  input  logic [ROW_W-1:0] vertical_displayed,
  input  logic [ROW_W-1:0] v_sync_position,
  input  logic [RA_W-1:0]  maximum_scanline,
  output logic             Horizontal,
  output logic             Horizontal_End,
  output logic             Scanline_End,
  output logic             V_total,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic [RA_W-1:0]  RA
);

  logic [H_W-1:0]   r_h_count;
  logic [RA_W-1:0]  r_ra;
  logic [ROW_W-1:0] r_row;
  logic [RA_W-1:0]  r_adj_count;
  vstate_t          r_state;

  logic w_horizontal;
  logic w_horizontal_end;
  logic w_row_last_scan;
  logic w_scanline_end;
  logic w_adj_last;
  logic w_vtotal;
  logic w_hs_start;
  logic w_vs_start;

  // Horizontal decode: both strobes are qualified by the character clock.
  assign w_horizontal     = video_clock_enable & (r_h_count == horizontal_total);
  assign w_horizontal_end = video_clock_enable & (r_h_count == horizontal_displayed);

  // Vertical decode from the registered counters.
  assign w_row_last_scan = (r_state == ST_ROWS) && (r_ra == maximum_scanline);
  assign w_adj_last      = (r_state == ST_ADJUST) &&
                           (r_adj_count == (vertical_total_adjust - 5'd1));
  assign w_scanline_end  = w_horizontal & w_row_last_scan;
  assign w_vtotal        = w_horizontal &
                           ((w_row_last_scan && (r_row == vertical_total) &&
                             (vertical_total_adjust == '0)) || w_adj_last);

  // Character counter: wraps at R0, or free-runs through 255 if R0 was lowered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h_count <= '0;
    end else if (video_clock_enable) begin
      if (r_h_count == horizontal_total) begin
        r_h_count <= '0;
      end else begin
        r_h_count <= r_h_count + 8'd1;
      end
    end
  end

  // Vertical state machine: steps once per line on Horizontal.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_ROWS;
      r_ra        <= '0;
      r_row       <= '0;
      r_adj_count <= '0;
    end else if (w_horizontal) begin
      case (r_state)
        ST_ROWS: begin
          if (r_ra != maximum_scanline) begin
            r_ra <= r_ra + 5'd1;
          end else begin
            r_ra <= '0;
            if (r_row != vertical_total) begin
              r_row <= r_row + 7'd1;
            end else if (vertical_total_adjust == '0) begin
              r_row <= '0;
            end else begin
              r_state     <= ST_ADJUST;
              r_adj_count <= '0;
            end
          end
        end
        ST_ADJUST: begin
          if (w_adj_last) begin
            r_state <= ST_ROWS;
            r_row   <= '0;
            r_ra    <= '0;
          end else begin
            r_adj_count <= r_adj_count + 5'd1;
          end
        end
        default: r_state <= ST_ROWS;
      endcase
    end
  end

  // VSYNC starts on the Horizontal that lands on scanline 0 of row R7.
  always_comb begin
    w_vs_start = 1'b0;
    if (w_horizontal) begin
      if (w_vtotal) begin
        w_vs_start = (v_sync_position == '0);
      end else if (w_row_last_scan && (r_row != vertical_total)) begin
        w_vs_start = ((r_row + 7'd1) == v_sync_position);
      end else if ((r_state == ST_ROWS) && !w_row_last_scan && (r_ra == 5'd31)) begin
        w_vs_start = (r_row == v_sync_position);
      end
    end
  end

  assign w_hs_start = video_clock_enable & (r_h_count == h_sync_position);

  kf6845_sync_pulse_generator #(
    .ZERO_IS_16(SYNC_ZERO_IS_16)
  ) u_hsync (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_hs_start),
    .step    (video_clock_enable),
    .width   (sync_width[3:0]),
    .pulse   (HSYNC)
  );

  kf6845_sync_pulse_generator #(
    .ZERO_IS_16(SYNC_ZERO_IS_16)
  ) u_vsync (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_vs_start),
    .step    (w_horizontal),
    .width   (sync_width[7:4]),
    .pulse   (VSYNC)
  );

  assign Horizontal     = w_horizontal;
  assign Horizontal_End = w_horizontal_end;
  assign Scanline_End   = w_scanline_end;
  assign V_total        = w_vtotal;
  assign DE             = (r_h_count < horizontal_displayed) && (r_state == ST_ROWS) &&
                          (r_row < vertical_displayed);
  assign RA             = (r_state == ST_ROWS) ? r_ra : r_adj_count;

endmodule
